uart_echo_fifo: RTL and testbench

- Parametrised successor to the board-level UART echo.
- Contains its own RX and TX bit engines, with a FIFO between them so back-to-back received bytes are buffered.
- Honours host flow control: uart_rts gates TX, and uart_cts is driven from FIFO fill level.
- Latches the last good byte to the LEDs. Sits directly under the board top; pins go straight to the FTDI UART.

---
 rtl/uart_echo_fifo.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// UART echo: RX engine -> FIFO -> TX engine with RTS/CTS flow control and an LED latch of the last good byte.
// Build with UART_PARITY_EN defined for even-parity frames and the sticky parity_err output.
module uart_echo_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CTS_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic                 uart_rts,
    output logic                 uart_cts,
    output logic [DATA_BITS-1:0] led,
`ifdef UART_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overflow
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CTS_LEVEL = (PTR_W + 1)'(FIFO_DEPTH - CTS_MARGIN);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    // stage p0/p1: two-flop synchronisers, idle-high
    logic rx_p0, rx_p1, rts_p0, rts_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0  <= 1'b1;
            rx_p1  <= 1'b1;
            rts_p0 <= 1'b1;
            rts_p1 <= 1'b1;
        end else begin
            rx_p0  <= uart_rx;
            rx_p1  <= rx_p0;
            rts_p0 <= uart_rts;
            rts_p1 <= rts_p0;
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 full, wr_en, tx_pop, rx_push;
    logic [DATA_BITS-1:0] rx_byte, head;

    assign full  = (count == FULL_CNT);
    assign wr_en = rx_push && (!full || tx_pop);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            uart_cts <= 1'b1;
            led      <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, tx_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a dropped byte still counts as a good frame for the LEDs
            if (rx_push && full && !tx_pop) overflow <= 1'b1;
            if (rx_push) led <= rx_byte;
            uart_cts <= (count >= CTS_LEVEL);
        end
    end

    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [BIT_W-1:0]     rx_bits;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_tick, rx_par_bad;

    assign rx_tick = (rx_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bits    <= '0;
            rx_push    <= 1'b0;
            rx_par_bad <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_par_bad <= 1'b0;
                    if (!rx_p1) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt  <= '0;
                        rx_bits <= rx_bits + 1'b1;
                        if (rx_bits == BITS_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PAR;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PAR: begin
                    if (rx_tick) begin
                        rx_cnt     <= '0;
                        rx_state   <= RX_STOP;
                        rx_par_bad <= (rx_p1 != ^rx_sh);
                        if (rx_p1 != ^rx_sh) parity_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        rx_push  <= rx_p1 && !rx_par_bad;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_tick) rx_sh <= {rx_p1, rx_sh[DATA_BITS-1:1]};
        if (rx_state == RX_STOP && rx_tick) rx_byte <= rx_sh;
    end

    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [BIT_W-1:0]     tx_bits;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_tick;

    assign tx_tick = (tx_cnt == DIV_LAST);
    // rts is only honoured between frames
    assign tx_pop  = (tx_state == TX_IDLE) && (count != '0) && !rts_p1;

`ifdef UART_PARITY_EN
    logic tx_par;
    always_ff @(posedge clk) begin
        if (tx_pop) tx_par <= ^head;
    end
`endif

    always_ff @(posedge clk) begin
        if (tx_pop) tx_sh <= head;
        else if (tx_state == TX_DATA && tx_tick) tx_sh <= tx_sh >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_bits  <= '0;
                        tx_state <= TX_DATA;
                        uart_tx  <= tx_sh[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt  <= '0;
                        tx_bits <= tx_bits + 1'b1;
                        if (tx_bits == BITS_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state <= TX_PAR;
                            uart_tx  <= tx_par;
`else
                            tx_state <= TX_STOP;
                            uart_tx  <= 1'b1;
`endif
                        end else begin
                            uart_tx <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PAR: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: serial driver, frame-decoding monitor on uart_tx, queue-based reference model.
module tb_uart_echo_fifo;

    localparam int DIV   = 10;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int NS = 11;
`else
    localparam int NS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rts = 1'b0;
    logic       uart_tx, uart_cts, overflow;
    logic [7:0] led;
`ifdef UART_PARITY_EN
    logic       parity_err;
    bit         bad_par = 1'b0;
`endif

    uart_echo_fifo #(
        .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CTS_MARGIN(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rx(rx),
        .uart_tx(uart_tx),
        .uart_rts(rts),
        .uart_cts(uart_cts),
        .led(led),
`ifdef UART_PARITY_EN
        .parity_err(parity_err),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // uart_tx monitor: decodes frames by mid-bit sampling, drops frames cut by reset
    logic [7:0] mon_q[$];
    longint     start_q[$];
    longint     cyc = 0;
    bit         mon_busy = 1'b0;
    int         mon_cnt, mon_k;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % DIV == DIV / 2) begin
                mon_k = mon_cnt / DIV;
                if (mon_k == 0) check("tx_start_bit", uart_tx, 1'b0);
                else if (mon_k <= 8) mon_byte[mon_k-1] = uart_tx;
`ifdef UART_PARITY_EN
                else if (mon_k == 9) check("tx_parity_bit", uart_tx, ^mon_byte);
`endif
                if (mon_k == NS - 1) begin
                    check("tx_stop_bit", uart_tx, 1'b1);
                    mon_q.push_back(mon_byte);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(DIV);
        end
`ifdef UART_PARITY_EN
        rx = (^d) ^ bad_par;
        idle(DIV);
`endif
        rx = stop_bit;
        idle(DIV);
        rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && mon_q.size() < n; i++) @(negedge clk);
        check("frame_count", mon_q.size(), n);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_led;
        bit         exp_echo;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] exp_q[$];
    logic [7:0] led_m, d;
    logic       ok;
    longint     send_end;
    bit         found;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
        tbl[1] = '{8'h3C, 1'b0, 8'hA5, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h81, 1'b0, 8'hFF, 1'b0};
        tbl[5] = '{8'h5A, 1'b1, 8'h5A, 1'b1};

        idle(3);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_cts", uart_cts, 1'b1);
        check("rst_led", led, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cts_after_release", uart_cts, 1'b0);
        idle(5);

        // single-frame vectors, rts asserted
        for (int i = 0; i < 6; i++) begin
            mon_q.delete();
            start_q.delete();
            send_frame(tbl[i].data, tbl[i].stop);
            send_end = cyc;
            if (tbl[i].exp_echo) wait_frames(1, 150);
            else idle(150);
            idle(20);
            check("tbl_led", led, tbl[i].exp_led);
            check("tbl_echo_count", mon_q.size(), tbl[i].exp_echo);
            if (tbl[i].exp_echo && mon_q.size() > 0) begin
                check("tbl_echo_byte", mon_q[0], tbl[i].data);
                check_range("echo_latency", start_q[0] - send_end, -10, 5);
            end
        end

        // short glitch on rx must not start a frame
        mon_q.delete();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(200);
        check("glitch_no_echo", mon_q.size(), 0);
        check("glitch_led", led, 8'h5A);

        // random frames with occasional framing errors
        mon_q.delete();
        exp_q.delete();
        led_m = 8'h5A;
        for (int i = 0; i < 14; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok);
            if (ok) begin
                exp_q.push_back(d);
                led_m = d;
            end
            idle($urandom_range(0, 15) + (ok ? 0 : DIV));
        end
        wait_frames(exp_q.size(), 400);
        idle(20);
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) check("rand_byte", mon_q[i], exp_q[i]);
        check("rand_led", led, led_m);
        check("rand_overflow", overflow, 1'b0);

`ifdef UART_PARITY_EN
        mon_q.delete();
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1);
        bad_par = 1'b0;
        idle(150);
        check("par_bad_no_echo", mon_q.size(), 0);
        check("par_err_set", parity_err, 1'b1);
        check("par_bad_led", led, led_m);
        send_frame(8'h07, 1'b1);
        wait_frames(1, 150);
        if (mon_q.size() > 0) check("par_good_byte", mon_q[0], 8'h07);
        idle(20);
`endif

        // flow control: hold rts, fill to the CTS threshold, then release
        mon_q.delete();
        start_q.delete();
        rts = 1'b1;
        idle(4);
        for (int b = 1; b <= 6; b++) begin
            send_frame(8'(b), 1'b1);
            idle(2);
            if (b == 5) check("cts_at_5", uart_cts, 1'b0);
        end
        check("cts_at_6", uart_cts, 1'b1);
        check("held_no_tx", start_q.size(), 0);
        check("held_tx_idle", uart_tx, 1'b1);
        rts = 1'b0;
        wait_frames(6, 800);
        idle(20);
        for (int i = 0; i < 6 && i < mon_q.size(); i++) check("flow_byte", mon_q[i], 8'(i + 1));
        for (int i = 1; i < start_q.size(); i++) check_range("flow_spacing", start_q[i] - start_q[i-1], 100, 101);
        check("cts_drained", uart_cts, 1'b0);

        // overflow: nine bytes into an eight-entry FIFO
        mon_q.delete();
        rts = 1'b1;
        idle(4);
        for (int b = 0; b < 8; b++) begin
            send_frame(8'h10 + 8'(b), 1'b1);
            idle(2);
        end
        check("full_no_overflow", overflow, 1'b0);
        check("full_cts", uart_cts, 1'b1);
        send_frame(8'h18, 1'b1);
        idle(5);
        check("overflow_set", overflow, 1'b1);
        check("overflow_led", led, 8'h18);
        rts = 1'b0;
        wait_frames(8, 1000);
        idle(150);
        check("overflow_frames", mon_q.size(), 8);
        for (int i = 0; i < 8 && i < mon_q.size(); i++) check("overflow_byte", mon_q[i], 8'h10 + 8'(i));
        check("overflow_sticky", overflow, 1'b1);

        // async reset in the middle of a transmitted frame, one byte still queued
        rts = 1'b1;
        idle(4);
        send_frame(8'hF0, 1'b1);
        idle(2);
        send_frame(8'h99, 1'b1);
        idle(2);
        mon_q.delete();
        start_q.delete();
        rts = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) found = 1'b1;
        end
        check("reset_frame_started", found, 1'b1);
        idle(45);
        check("tx_bit3_before_reset", uart_tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", uart_tx, 1'b1);
        check("async_rst_overflow", overflow, 1'b0);
        check("async_rst_cts", uart_cts, 1'b1);
        check("async_rst_led", led, 8'h00);
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("cts_after_rerelease", uart_cts, 1'b0);
        idle(300);
        check("fifo_flushed", mon_q.size(), 0);
        send_frame(8'h55, 1'b1);
        wait_frames(1, 150);
        if (mon_q.size() > 0) check("post_reset_byte", mon_q[0], 8'h55);
        check("post_reset_led", led, 8'h55);
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
